mips_encode_loader: RTL and testbench
=====================================

// Module: mips_encode_loader
// PURPOSE
//  Inverse of mips_decode: packs a stream of instruction descriptors (kind + fields)
//  into 32-bit MIPS machine words and writes them sequentially into instruction memory.
//  Used by the test harness and boot loader to fill imem before the core runs.
//  Supports exactly the instruction set mips_decode accepts; other kinds are rejected and counted.
// PARAMETERS
//  ADDR_W  10    imem word-address width
//  DEPTH   1024  words loadable before full (1..2**ADDR_W)
// PORTS
//  clock       in   1       system clock; all state changes on rising edge
//  reset       in   1       synchronous, active-high
//  clear       in   1       synchronous restart: address/counters/flags to reset values
//  in_valid    in   1       descriptor valid
//  in_ready    out  1       loader accepts descriptor this cycle
//  in_kind     in   5       0 add,1 sub,2 and,3 or,4 nor,5 xor,6 slt,7 jr,8 addm,9 addi,10 andi,
//                           11 ori,12 xori,13 lui,14 beq,15 bne,16 j,17 lw,18 lbu,19 sw,20 sb; 21-31 illegal
//  in_rs       in   5       rs field
//  in_rt       in   5       rt field
//  in_rd       in   5       rd field
//  in_imm      in   16      immediate / branch offset
//  in_target   in   26      jump target
//  imem_we     out  1       write strobe, one cycle per encoded word
//  imem_addr   out  ADDR_W  word address of imem_data
//  imem_data   out  32      encoded instruction
//  word_count  out  ADDR_W+1 words written since reset/clear
//  full        out  1       DEPTH words written
//  bad_kind    out  1       sticky: an illegal kind was consumed
//  err_count   out  8       illegal kinds consumed, saturates at 255
// BEHAVIOUR
//  - Reset/clear values: in_ready=1, imem_we=0, imem_addr=0, imem_data=0, word_count=0,
//    full=0, bad_kind=0, err_count=0; state=LOAD.
//  - States: LOAD (in_ready=1) -> FULL when word_count reaches DEPTH; FULL (in_ready=0) exits only on reset/clear.
//  - Accept = in_valid & in_ready. Latency 1: accepted legal descriptor produces imem_we=1 with
//    imem_data/imem_addr registered the next cycle; imem_we is 0 in every other cycle.
//  - imem_addr = word_count at accept; word_count increments on the same edge imem_we asserts.
//  - Encoding (opcode/funct from the shared `OP_*/`OP0_* defines):
//    R-type (0-6,8): {`OP_OTHER0, rs, rt, rd, 5'b0, funct}; jr: {`OP_OTHER0, rs, 15'b0, `OP0_JR}.
//    I-type (9-12,14,15,17-20): {op, rs, rt, imm}; lui: {`OP_LUI, 5'b0, rt, imm}.
//    j: {`OP_J, target}. Unused input fields are ignored, never leak into the word.
//  - Illegal kind (21-31): consumed (handshake completes), no imem_we, address not advanced,
//    bad_kind set, err_count +1 unless already 255.
//  - Full: the accept of word DEPTH-1 moves to FULL; in_ready drops the following cycle; the last
//    write still issues normally. Illegal kinds are not counted while FULL (none accepted).
//  - clear and reset have priority over accept in the same cycle: that beat is not consumed,
//    any write pending for the next cycle is suppressed (imem_we=0).
//  - in_valid may drop without acceptance; no state change when in_valid=0.
// TESTING
//  - reset, kind=0 rs=1 rt=2 rd=3 -> next cycle imem_we=1 addr=0 data=0x00221820, word_count=1.
//  - kind=9 rs=0 rt=8 imm=5, then kind=13 rt=1 imm=0x1234 rs=7 -> 0x20080005 @0, 0x3C011234 @1.
//  - kind=16 target=0x0100000 back-to-back with kind=7 rs=31 -> 0x08100000 @0, 0x03E00008 @1, no gaps.
//  - kind=25 between two legal beats -> legal words at addr 0,1; bad_kind=1, err_count=1; 256 illegal -> 255.
//  - DEPTH=4: stream 6 valid beats -> 4 writes (addr 0-3), full=1, in_ready=0, last 2 beats held.
//  - clear asserted with in_valid same cycle -> beat not accepted, next write lands at addr 0, counts 0.

Source files
------------

// File: rtl/mips_encode_loader.sv
// Packs instruction descriptors into 32-bit MIPS words and streams them into
// instruction memory at sequential word addresses until DEPTH words are written.
module mips_encode_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              bad_kind,
  output logic [7:0]        err_count
);

  // Major opcodes and R-type function codes shared with the decoder
  localparam logic [5:0] OP_OTHER0 = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] OP0_JR    = 6'h08;
  localparam logic [5:0] OP0_ADD   = 6'h20;
  localparam logic [5:0] OP0_SUB   = 6'h22;
  localparam logic [5:0] OP0_AND   = 6'h24;
  localparam logic [5:0] OP0_OR    = 6'h25;
  localparam logic [5:0] OP0_XOR   = 6'h26;
  localparam logic [5:0] OP0_NOR   = 6'h27;
  localparam logic [5:0] OP0_SLT   = 6'h2A;
  localparam logic [5:0] OP0_ADDM  = 6'h2C;

  localparam logic [4:0] K_ADD  = 5'd0;
  localparam logic [4:0] K_SUB  = 5'd1;
  localparam logic [4:0] K_AND  = 5'd2;
  localparam logic [4:0] K_OR   = 5'd3;
  localparam logic [4:0] K_NOR  = 5'd4;
  localparam logic [4:0] K_XOR  = 5'd5;
  localparam logic [4:0] K_SLT  = 5'd6;
  localparam logic [4:0] K_JR   = 5'd7;
  localparam logic [4:0] K_ADDM = 5'd8;
  localparam logic [4:0] K_ADDI = 5'd9;
  localparam logic [4:0] K_ANDI = 5'd10;
  localparam logic [4:0] K_ORI  = 5'd11;
  localparam logic [4:0] K_XORI = 5'd12;
  localparam logic [4:0] K_LUI  = 5'd13;
  localparam logic [4:0] K_BEQ  = 5'd14;
  localparam logic [4:0] K_BNE  = 5'd15;
  localparam logic [4:0] K_J    = 5'd16;
  localparam logic [4:0] K_LW   = 5'd17;
  localparam logic [4:0] K_LBU  = 5'd18;
  localparam logic [4:0] K_SW   = 5'd19;
  localparam logic [4:0] K_SB   = 5'd20;

  localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic {S_LOAD = 1'b0, S_FULL = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        accept_p0;
  logic        legal_p0;
  logic        vld_p0;
  logic        bad_p0;
  logic [31:0] word_p0;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {OP_OTHER0, rs, rt, rd, 5'b0, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic kind_legal(input logic [4:0] kind);
    return kind <= K_SB;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  // Only the fields each format owns are placed; everything else stays zero.
  function automatic logic [31:0] encode(input logic [4:0] kind, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [15:0] imm, input logic [25:0] target);
    logic [31:0] w;
    w = '0;
    case (kind)
      K_ADD:   w = rtype(rs, rt, rd, OP0_ADD);
      K_SUB:   w = rtype(rs, rt, rd, OP0_SUB);
      K_AND:   w = rtype(rs, rt, rd, OP0_AND);
      K_OR:    w = rtype(rs, rt, rd, OP0_OR);
      K_NOR:   w = rtype(rs, rt, rd, OP0_NOR);
      K_XOR:   w = rtype(rs, rt, rd, OP0_XOR);
      K_SLT:   w = rtype(rs, rt, rd, OP0_SLT);
      K_JR:    w = {OP_OTHER0, rs, 15'b0, OP0_JR};
      K_ADDM:  w = rtype(rs, rt, rd, OP0_ADDM);
      K_ADDI:  w = itype(OP_ADDI, rs, rt, imm);
      K_ANDI:  w = itype(OP_ANDI, rs, rt, imm);
      K_ORI:   w = itype(OP_ORI, rs, rt, imm);
      K_XORI:  w = itype(OP_XORI, rs, rt, imm);
      K_LUI:   w = itype(OP_LUI, 5'b0, rt, imm);
      K_BEQ:   w = itype(OP_BEQ, rs, rt, imm);
      K_BNE:   w = itype(OP_BNE, rs, rt, imm);
      K_J:     w = {OP_J, target};
      K_LW:    w = itype(OP_LW, rs, rt, imm);
      K_LBU:   w = itype(OP_LBU, rs, rt, imm);
      K_SW:    w = itype(OP_SW, rs, rt, imm);
      K_SB:    w = itype(OP_SB, rs, rt, imm);
      default: w = '0;
    endcase
    return w;
  endfunction

  // Stage p0: handshake, legality and encoding of the presented descriptor
  always_comb begin
    state_nxt = state;
    in_ready  = (state == S_LOAD);
    full      = (state == S_FULL);
    accept_p0 = in_valid & in_ready;
    legal_p0  = kind_legal(in_kind);
    vld_p0    = accept_p0 & legal_p0;
    bad_p0    = accept_p0 & ~legal_p0;
    word_p0   = encode(in_kind, in_rs, in_rt, in_rd, in_imm, in_target);
    if (vld_p0 && word_count == LAST_WORD)
      state_nxt = S_FULL;
  end

  // Stage p1: registered imem write port and counters
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state      <= S_LOAD;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_data  <= '0;
      word_count <= '0;
      bad_kind   <= 1'b0;
      err_count  <= '0;
    end else begin
      state   <= state_nxt;
      imem_we <= vld_p0;
      if (vld_p0) begin
        imem_addr  <= word_count[ADDR_W-1:0];
        imem_data  <= word_p0;
        word_count <= word_count + 1'b1;
      end
      if (bad_p0) begin
        bad_kind  <= 1'b1;
        err_count <= sat_inc(err_count);
      end
    end
  end

endmodule

// File: tb/tb_mips_encode_loader.sv
// Directed bench for mips_encode_loader: the driver queues expected imem writes,
// a negedge monitor pops and compares each write the DUT issues.
module tb_mips_encode_loader;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;

  logic              clock = 1'b0;
  logic              reset, clear, in_valid, in_ready;
  logic [4:0]        in_kind, in_rs, in_rt, in_rd;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              imem_we, full, bad_kind;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        err_count;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   model_addr = 0;

  mips_encode_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm(in_imm), .in_target(in_target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
    .word_count(word_count), .full(full), .bad_kind(bad_kind), .err_count(err_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every write must match the oldest expected word.
  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%08h expected no write",
                 imem_addr, imem_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("write_addr", 32'(imem_addr), e.addr);
        chk("write_data", imem_data, e.data);
      end
    end
  end

  // One-cycle beat presented at a negedge; expected write queued at the edge.
  task automatic beat(input logic [4:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                      input logic [31:0] exp_word, input logic exp_acc);
    in_valid  = 1'b1;
    in_kind   = k;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_imm    = imm;
    in_target = tgt;
    chk("in_ready", 32'(in_ready), 32'(exp_acc));
    @(posedge clock);
    if (exp_acc && k <= 5'd20) begin
      sb_q.push_back('{addr: 32'(model_addr), data: exp_word});
      model_addr++;
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  // Clear with a legal beat offered in the same cycle: the beat must be dropped.
  task automatic do_clear();
    clear     = 1'b1;
    in_valid  = 1'b1;
    in_kind   = 5'd0;
    in_rs     = 5'd1;
    in_rt     = 5'd1;
    in_rd     = 5'd1;
    @(posedge clock);
    model_addr = 0;
    @(negedge clock);
    clear    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0;
    in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_imem_data", imem_data, 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_bad_kind", 32'(bad_kind), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    reset = 1'b0;
    idle(1);

    // add r3,r1,r2
    beat(5'd0, 5'd1, 5'd2, 5'd3, 16'hFFFF, 26'h3FFFFFF, 32'h00221820, 1'b1);
    chk("add_word_count", 32'(word_count), 32'd1);
    idle(2);

    // clear while a beat is valid; next write must restart at addr 0
    do_clear();
    chk("clr_word_count", 32'(word_count), 32'd0);
    chk("clr_imem_we", 32'(imem_we), 32'd0);

    // addi / lui with junk in unused fields
    beat(5'd9, 5'd0, 5'd8, 5'd31, 16'h0005, 26'h3FFFFFF, 32'h20080005, 1'b1);
    beat(5'd13, 5'd7, 5'd1, 5'd31, 16'h1234, 26'h3FFFFFF, 32'h3C011234, 1'b1);
    chk("ilui_word_count", 32'(word_count), 32'd2);
    idle(2);

    // j then jr back-to-back, writes in consecutive cycles
    do_clear();
    beat(5'd16, 5'd3, 5'd4, 5'd5, 16'hFFFF, 26'h0100000, 32'h08100000, 1'b1);
    chk("j_we_nogap", 32'(imem_we), 32'd1);
    beat(5'd7, 5'd31, 5'd5, 5'd9, 16'hFFFF, 26'h3FFFFFF, 32'h03E00008, 1'b1);
    chk("jr_we_nogap", 32'(imem_we), 32'd1);
    idle(2);

    // illegal kind between legal beats
    do_clear();
    beat(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221820, 1'b1);
    beat(5'd25, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0, 1'b1);
    chk("ill_we_low", 32'(imem_we), 32'd0);
    beat(5'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 32'h00853022, 1'b1);
    idle(2);
    chk("ill_word_count", 32'(word_count), 32'd2);
    chk("ill_bad_kind", 32'(bad_kind), 32'd1);
    chk("ill_err_count", 32'(err_count), 32'd1);

    // saturate err_count: 254 more reach 255, 2 more stay at 255
    for (int i = 0; i < 254; i++)
      beat(5'(21 + (i % 11)), 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 32'h0, 1'b1);
    chk("sat_err_255", 32'(err_count), 32'd255);
    for (int i = 0; i < 2; i++)
      beat(5'd31, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 32'h0, 1'b1);
    chk("sat_err_hold", 32'(err_count), 32'd255);
    chk("sat_word_count", 32'(word_count), 32'd2);

    // fill DEPTH=4 words, then two beats that must be held
    do_clear();
    chk("fill_err_cleared", 32'(err_count), 32'd0);
    beat(5'd11, 5'd1, 5'd2, 5'd7, 16'hABCD, 26'h0, 32'h3422ABCD, 1'b1);
    beat(5'd14, 5'd3, 5'd4, 5'd7, 16'hFFFF, 26'h0, 32'h1064FFFF, 1'b1);
    beat(5'd17, 5'd29, 5'd8, 5'd7, 16'h0004, 26'h0, 32'h8FA80004, 1'b1);
    beat(5'd19, 5'd29, 5'd9, 5'd7, 16'h0008, 26'h0, 32'hAFA90008, 1'b1);
    beat(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221820, 1'b0);
    beat(5'd30, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0, 1'b0);
    idle(2);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_word_count", 32'(word_count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_err_count", 32'(err_count), 32'd0);
    chk("full_bad_kind", 32'(bad_kind), 32'd0);

    // clear leaves FULL; nor lands at addr 0
    do_clear();
    chk("reclr_full", 32'(full), 32'd0);
    beat(5'd4, 5'd7, 5'd8, 5'd9, 16'hFFFF, 26'h3FFFFFF, 32'h00E84827, 1'b1);
    idle(3);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
